// File: rtl/stream_framer_pkg.sv
// Shared state type, default framing constants and sizing helper for stream_framer.
// STREAM_FRAMER_CHECKSUM_EN adds the csum_s state to the enum.
package stream_framer_pkg;

    typedef enum logic [2:0] {
        idle_s,
        hdr_sync_s,
        hdr_seq_s,
        payload_s,
`ifdef STREAM_FRAMER_CHECKSUM_EN
        csum_s,
`endif
        tail_0_s,
        tail_1_s
    } stream_framer_state_e;

    localparam logic [7:0] sync_word_default_c   = 8'hA5;
    localparam logic [7:0] tail_word_0_default_c = 8'h0D;
    localparam logic [7:0] tail_word_1_default_c = 8'h0A;

    // Number of packed words needed to carry len elements (ceiling division).
    function automatic int words_for_len(input int len, input int packed_num);
        return (len + packed_num - 1) / packed_num;
    endfunction

endpackage

// File: rtl/stream_framer_packer.sv
// Packs unpacked elements into packed words, lowest element in the LSBs.
// flush_i emits a zero-padded partial word; a flush on an empty packer emits nothing.
module stream_framer_packer #(
    parameter int unpacked_width_p = 1,
    parameter int packed_num_p     = 8,
    parameter int packed_width_p   = unpacked_width_p * packed_num_p
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic [unpacked_width_p-1:0] unpacked_i,
    input  logic                        flush_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [packed_width_p-1:0]   data_o
);

    localparam int cnt_w_lp = $clog2(packed_num_p + 1);
    localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(packed_num_p - 1);

    logic [packed_width_p-1:0] acc_r;
    logic [packed_width_p-1:0] acc_next;
    logic [cnt_w_lp-1:0]       cnt_r;
    logic                      flush_pend_r;
    logic                      out_free;
    logic                      in_fire;
    logic                      word_full;
    logic                      flush_req;
    logic                      flush_go;

    // The output slot frees up in the same cycle it is consumed, so a full word
    // can be loaded behind a word that is leaving without a bubble.
    assign out_free  = !valid_o || ready_i;
    assign ready_o   = out_free && !flush_pend_r;
    assign in_fire   = valid_i && ready_o;
    assign word_full = in_fire && (cnt_r == last_cnt_lp);
    assign flush_req = flush_i || flush_pend_r;
    assign flush_go  = flush_req && out_free && !in_fire && (cnt_r != '0);

    // NOTE: every variable written in always_comb gets a default first; a path
    // that leaves it unassigned would infer a latch.
    always_comb begin
        acc_next = acc_r;
        if (in_fire) begin
            acc_next[int'(cnt_r) * unpacked_width_p +: unpacked_width_p] = unpacked_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            acc_r        <= '0;
            cnt_r        <= '0;
            flush_pend_r <= 1'b0;
            valid_o      <= 1'b0;
            data_o       <= '0;
        end else begin
            if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            if (word_full) begin
                data_o  <= acc_next;
                valid_o <= 1'b1;
                acc_r   <= '0;
                cnt_r   <= '0;
            end else if (flush_go) begin
                data_o  <= acc_r;
                valid_o <= 1'b1;
                acc_r   <= '0;
                cnt_r   <= '0;
            end else if (in_fire) begin
                acc_r <= acc_next;
                cnt_r <= cnt_r + 1'b1;
            end
            // A flush that cannot go yet waits; one on an empty packer is dropped.
            flush_pend_r <= flush_req && !flush_go && ((cnt_r != '0) || in_fire);
        end
    end

endmodule

// File: rtl/stream_framer.sv
// Wraps packed payload words in a sync/sequence header and a two-word tail.
// Optional macro STREAM_FRAMER_CHECKSUM_EN inserts a payload checksum word before the tail.
module stream_framer
    import stream_framer_pkg::*;
#(
    parameter int         unpacked_width_p = 1,
    parameter int         packed_num_p     = 8,
    parameter int         packed_width_p   = unpacked_width_p * packed_num_p,
    parameter int         max_len_elems_p  = 8192,
    parameter logic [7:0] sync_word_p      = sync_word_default_c,
    parameter logic [7:0] tail_word_0_p    = tail_word_0_default_c,
    parameter logic [7:0] tail_word_1_p    = tail_word_1_default_c
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [$clog2(max_len_elems_p+1)-1:0]   len_i,
    input  logic                                   valid_i,
    output logic                                   ready_o,
    input  logic [unpacked_width_p-1:0]            unpacked_i,
    output logic                                   valid_o,
    input  logic                                   ready_i,
    output logic [packed_width_p-1:0]              data_o,
    output logic [packed_width_p-1:0]              seq_o,
    output logic                                   busy_o
);

    localparam int len_w_lp = $clog2(max_len_elems_p + 1);
    localparam logic [len_w_lp-1:0]       max_len_lp = len_w_lp'(max_len_elems_p);
    localparam logic [packed_width_p-1:0] sync_lp    = packed_width_p'(sync_word_p);
    localparam logic [packed_width_p-1:0] tail_0_lp  = packed_width_p'(tail_word_0_p);
    localparam logic [packed_width_p-1:0] tail_1_lp  = packed_width_p'(tail_word_1_p);
`ifdef STREAM_FRAMER_CHECKSUM_EN
    localparam stream_framer_state_e after_payload_lp = csum_s;
`else
    localparam stream_framer_state_e after_payload_lp = tail_0_s;
`endif

    stream_framer_state_e      state_r;
    logic [len_w_lp-1:0]       len_r;
    logic [len_w_lp-1:0]       exp_words_r;
    logic [len_w_lp-1:0]       in_cnt_r;
    logic [len_w_lp-1:0]       out_cnt_r;
    logic [len_w_lp-1:0]       len_clamped;
    logic [packed_width_p-1:0] seq_r;
    logic                      flush_r;
`ifdef STREAM_FRAMER_CHECKSUM_EN
    logic [packed_width_p-1:0] csum_r;
`endif

    logic                      in_open;
    logic                      in_fire;
    logic                      out_fire;
    logic                      pk_valid_i;
    logic                      pk_ready_o;
    logic                      pk_valid_o;
    logic                      pk_ready_i;
    logic [packed_width_p-1:0] pk_data_o;

    assign len_clamped = (len_i > max_len_lp) ? max_len_lp : len_i;
    assign in_open     = (state_r == payload_s) && (in_cnt_r < len_r);
    assign pk_valid_i  = valid_i && in_open;
    assign pk_ready_i  = ready_i && (state_r == payload_s);
    assign ready_o     = pk_ready_o && in_open;
    assign in_fire     = valid_i && ready_o;
    assign out_fire    = valid_o && ready_i;
    assign busy_o      = (state_r != idle_s);
    assign seq_o       = seq_r;

    stream_framer_packer #(
        .unpacked_width_p (unpacked_width_p),
        .packed_num_p     (packed_num_p),
        .packed_width_p   (packed_width_p)
    ) u_packer (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .valid_i    (pk_valid_i),
        .ready_o    (pk_ready_o),
        .unpacked_i (unpacked_i),
        .flush_i    (flush_r),
        .valid_o    (pk_valid_o),
        .ready_i    (pk_ready_i),
        .data_o     (pk_data_o)
    );

    // Output words are decoded from registered state or taken from the packer's
    // output register, so they stay stable while the downstream stalls.
    always_comb begin
        valid_o = 1'b0;
        data_o  = '0;
        unique case (state_r)
            hdr_sync_s: begin
                valid_o = 1'b1;
                data_o  = sync_lp;
            end
            hdr_seq_s: begin
                valid_o = 1'b1;
                data_o  = seq_r;
            end
            payload_s: begin
                valid_o = pk_valid_o;
                data_o  = pk_data_o;
            end
`ifdef STREAM_FRAMER_CHECKSUM_EN
            csum_s: begin
                valid_o = 1'b1;
                data_o  = csum_r;
            end
`endif
            tail_0_s: begin
                valid_o = 1'b1;
                data_o  = tail_0_lp;
            end
            tail_1_s: begin
                valid_o = 1'b1;
                data_o  = tail_1_lp;
            end
            default: begin
                valid_o = 1'b0;
                data_o  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r     <= idle_s;
            len_r       <= '0;
            exp_words_r <= '0;
            in_cnt_r    <= '0;
            out_cnt_r   <= '0;
            seq_r       <= '0;
            flush_r     <= 1'b0;
`ifdef STREAM_FRAMER_CHECKSUM_EN
            csum_r      <= '0;
`endif
        end else begin
            // The last element has been accepted; push out any partial word.
            flush_r <= in_fire && (in_cnt_r == len_r - 1'b1);
            if (in_fire) begin
                in_cnt_r <= in_cnt_r + 1'b1;
            end

            unique case (state_r)
                idle_s: begin
                    if (valid_i) begin
                        len_r       <= len_clamped;
                        exp_words_r <= len_w_lp'(words_for_len(int'(len_clamped), packed_num_p));
                        state_r     <= hdr_sync_s;
`ifdef STREAM_FRAMER_CHECKSUM_EN
                        csum_r      <= '0;
`endif
                    end
                end
                hdr_sync_s: begin
                    if (out_fire) state_r <= hdr_seq_s;
                end
                hdr_seq_s: begin
                    if (out_fire) state_r <= (len_r == '0) ? after_payload_lp : payload_s;
                end
                payload_s: begin
                    if (out_fire) begin
                        out_cnt_r <= out_cnt_r + 1'b1;
`ifdef STREAM_FRAMER_CHECKSUM_EN
                        csum_r    <= csum_r + pk_data_o;
`endif
                        if (out_cnt_r == exp_words_r - 1'b1) state_r <= after_payload_lp;
                    end
                end
`ifdef STREAM_FRAMER_CHECKSUM_EN
                csum_s: begin
                    if (out_fire) state_r <= tail_0_s;
                end
`endif
                tail_0_s: begin
                    if (out_fire) state_r <= tail_1_s;
                end
                tail_1_s: begin
                    if (out_fire) begin
                        seq_r       <= seq_r + 1'b1;
                        in_cnt_r    <= '0;
                        out_cnt_r   <= '0;
                        len_r       <= '0;
                        exp_words_r <= '0;
                        state_r     <= idle_s;
                    end
                end
                default: state_r <= idle_s;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_framer.sv
// Directed bench for stream_framer: header/tail framing, partial words, zero length,
// async reset, back-to-back packets and backpressure (checksum variant via STREAM_FRAMER_CHECKSUM_EN).
module tb_stream_framer;

    localparam int LW = $clog2(8192 + 1);

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [LW-1:0] len_i;
    logic          valid_i;
    logic          ready_o;
    logic [0:0]    unpacked_i;
    logic          valid_o;
    logic          ready_i;
    logic [7:0]    data_o;
    logic [7:0]    seq_o;
    logic          busy_o;

    int errors = 0;
    int checks = 0;

    logic [0:0] elem_mem [0:63];
    logic [7:0] obs_w [0:63];
    int         obs_n, obs_in, obs_stalls, obs_first, obs_last;
    bit         obs_timeout;
    logic [7:0] exp_seq;
    logic [7:0] exp_q [$];

    stream_framer dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .len_i      (len_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .unpacked_i (unpacked_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .seq_o      (seq_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Drives one packet from elem_mem and records every accepted output word.
    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic run_packet(input int len, input int bp_pct);
        int  idx = 0;
        int  cyc = 0;
        bit  started = 0;
        bit  done = 0;
        bit  held_v = 0;
        logic [7:0] held_d = '0;
        for (int i = 0; i < 64; i++) obs_w[i] = 8'hxx;
        obs_n = 0; obs_stalls = 0; obs_first = -1; obs_last = -1;
        while (!done && cyc < 2000) begin
            @(negedge clk_i);
            len_i      = started ? LW'($urandom) : LW'(len);
            valid_i    = !started || (idx < len);
            unpacked_i = (idx < len) ? elem_mem[idx] : 1'b0;
            ready_i    = ($urandom_range(99) >= bp_pct);
            #1;
            if (held_v && (!valid_o || data_o !== held_d)) obs_stalls++;
            held_v = valid_o && !ready_i;
            held_d = data_o;
            if (valid_i && ready_o) idx++;
            if (valid_o && ready_i) begin
                if (obs_n == 0) obs_first = cyc;
                obs_last = cyc;
                if (obs_n < 64) obs_w[obs_n] = data_o;
                obs_n++;
            end
            if (busy_o) started = 1;
            else if (started) done = 1;
            cyc++;
        end
        obs_timeout = !done;
        obs_in      = idx;
        valid_i     = 1'b0;
        ready_i     = 1'b1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1; len_i = LW'(16);
        repeat (2) @(negedge clk_i);
        #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (seq_o !== 8'h00) begin errors++; $display("FAIL reset_seq: got %h want 00", seq_o); end
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_o); end
        @(negedge clk_i);
        reset_i = 1'b0; valid_i = 1'b0;
        @(negedge clk_i); #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy got %b want 0", busy_o); end
        exp_seq = 8'h00;
    endtask

    task automatic test_all_ones();
        for (int i = 0; i < 16; i++) elem_mem[i] = 1'b1;
        run_packet(16, 0);
`ifdef STREAM_FRAMER_CHECKSUM_EN
        exp_q = '{8'hA5, 8'h00, 8'hFF, 8'hFF, 8'hFE, 8'h0D, 8'h0A};
`else
        exp_q = '{8'hA5, 8'h00, 8'hFF, 8'hFF, 8'h0D, 8'h0A};
`endif
        checks++; if (obs_timeout || obs_n !== exp_q.size()) begin errors++; $display("FAIL ones_count: got %0d words want %0d", obs_n, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (obs_w[i] !== exp_q[i]) begin errors++; $display("FAIL ones_word%0d: got %h want %h", i, obs_w[i], exp_q[i]); end
        end
        checks++; if (obs_first !== 1) begin errors++; $display("FAIL ones_latency: got cycle %0d want 1", obs_first); end
        checks++; if (obs_in !== 16) begin errors++; $display("FAIL ones_consumed: got %0d want 16", obs_in); end
        checks++; if (seq_o !== 8'h01) begin errors++; $display("FAIL ones_seq: got %h want 01", seq_o); end
        exp_seq = 8'h01;
    endtask

    task automatic test_partial();
        for (int i = 0; i < 10; i++) elem_mem[i] = ((i % 2) == 0) ? 1'b1 : 1'b0;
        run_packet(10, 0);
`ifdef STREAM_FRAMER_CHECKSUM_EN
        exp_q = '{8'hA5, 8'h01, 8'h55, 8'h01, 8'h56, 8'h0D, 8'h0A};
`else
        exp_q = '{8'hA5, 8'h01, 8'h55, 8'h01, 8'h0D, 8'h0A};
`endif
        checks++; if (obs_timeout || obs_n !== exp_q.size()) begin errors++; $display("FAIL partial_count: got %0d words want %0d", obs_n, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (obs_w[i] !== exp_q[i]) begin errors++; $display("FAIL partial_word%0d: got %h want %h", i, obs_w[i], exp_q[i]); end
        end
        checks++; if (obs_in !== 10) begin errors++; $display("FAIL partial_consumed: got %0d want 10", obs_in); end
        exp_seq = 8'h02;
    endtask

    task automatic test_zero_len();
        run_packet(0, 0);
`ifdef STREAM_FRAMER_CHECKSUM_EN
        exp_q = '{8'hA5, 8'h02, 8'h00, 8'h0D, 8'h0A};
`else
        exp_q = '{8'hA5, 8'h02, 8'h0D, 8'h0A};
`endif
        checks++; if (obs_timeout || obs_n !== exp_q.size()) begin errors++; $display("FAIL zero_count: got %0d words want %0d", obs_n, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (obs_w[i] !== exp_q[i]) begin errors++; $display("FAIL zero_word%0d: got %h want %h", i, obs_w[i], exp_q[i]); end
        end
        checks++; if (obs_in !== 0) begin errors++; $display("FAIL zero_consumed: got %0d want 0", obs_in); end
        checks++; if (obs_last - obs_first !== exp_q.size() - 1) begin errors++; $display("FAIL zero_gapless: got span %0d want %0d", obs_last - obs_first, exp_q.size() - 1); end
        exp_seq = 8'h03;
    endtask

    task automatic test_back_to_back();
        elem_mem[0] = 1'b1; elem_mem[1] = 1'b1; elem_mem[2] = 1'b0;
        for (int p = 0; p < 2; p++) begin
            run_packet(3, 0);
`ifdef STREAM_FRAMER_CHECKSUM_EN
            exp_q = '{8'hA5, exp_seq, 8'h03, 8'h03, 8'h0D, 8'h0A};
`else
            exp_q = '{8'hA5, exp_seq, 8'h03, 8'h0D, 8'h0A};
`endif
            checks++; if (obs_timeout || obs_n !== exp_q.size()) begin errors++; $display("FAIL b2b%0d_count: got %0d words want %0d", p, obs_n, exp_q.size()); end
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++; if (obs_w[i] !== exp_q[i]) begin errors++; $display("FAIL b2b%0d_word%0d: got %h want %h", p, i, obs_w[i], exp_q[i]); end
            end
            checks++; if (obs_first !== 1) begin errors++; $display("FAIL b2b%0d_latency: got cycle %0d want 1", p, obs_first); end
            exp_seq++;
        end
    endtask

    task automatic test_async_reset();
        int  idx = 0;
        int  cyc = 0;
        bit  stalled = 0;
        int  bad = 0;
        for (int i = 0; i < 16; i++) elem_mem[i] = 1'b1;
        len_i = LW'(16);
        // Accept headers, then stall the downstream once the first payload word is ready.
        while (!stalled && cyc < 100) begin
            @(negedge clk_i);
            valid_i    = 1'b1;
            unpacked_i = elem_mem[idx];
            ready_i    = (idx < 4);
            #1;
            if (valid_i && ready_o) idx++;
            if (valid_o && !ready_i && busy_o) stalled = 1;
            cyc++;
        end
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL areset_setup: valid got %b want 1", valid_o); end
        #2;
        reset_i = 1'b1;
        #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b want 0", busy_o); end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL areset_ready: got %b want 0", ready_o); end
        checks++; if (seq_o !== 8'h00) begin errors++; $display("FAIL areset_seq: got %h want 00", seq_o); end
        @(negedge clk_i);
        reset_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i); #1;
            if (valid_o !== 1'b0 || busy_o !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL areset_quiet: got %0d active cycles want 0", bad); end
        exp_seq = 8'h00;
        run_packet(8, 0);
`ifdef STREAM_FRAMER_CHECKSUM_EN
        exp_q = '{8'hA5, 8'h00, 8'hFF, 8'hFF, 8'h0D, 8'h0A};
`else
        exp_q = '{8'hA5, 8'h00, 8'hFF, 8'h0D, 8'h0A};
`endif
        checks++; if (obs_timeout || obs_n !== exp_q.size()) begin errors++; $display("FAIL areset_next_count: got %0d words want %0d", obs_n, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (obs_w[i] !== exp_q[i]) begin errors++; $display("FAIL areset_next_word%0d: got %h want %h", i, obs_w[i], exp_q[i]); end
        end
        exp_seq = 8'h01;
    endtask

    task automatic test_backpressure();
        int         len;
        logic [7:0] w;
        logic [7:0] cs;
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        exp_seq = 8'h00;
        for (int p = 0; p < 300; p++) begin
            len = $urandom_range(24);
            for (int i = 0; i < len; i++) elem_mem[i] = 1'($urandom_range(1));
            exp_q = {};
            exp_q.push_back(8'hA5);
            exp_q.push_back(exp_seq);
            cs = 8'h00;
            for (int i = 0; i < len; i += 8) begin
                w = 8'h00;
                for (int b = 0; b < 8; b++) if (i + b < len) w[b] = elem_mem[i + b];
                exp_q.push_back(w);
                cs = cs + w;
            end
`ifdef STREAM_FRAMER_CHECKSUM_EN
            exp_q.push_back(cs);
`endif
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            run_packet(len, 30);
            checks++; if (obs_timeout || obs_n !== exp_q.size()) begin errors++; $display("FAIL bp_count pkt=%0d: got %0d words want %0d", p, obs_n, exp_q.size()); end
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++; if (obs_w[i] !== exp_q[i]) begin errors++; $display("FAIL bp_word pkt=%0d idx=%0d: got %h want %h", p, i, obs_w[i], exp_q[i]); end
            end
            checks++; if (obs_in !== len) begin errors++; $display("FAIL bp_consumed pkt=%0d: got %0d want %0d", p, obs_in, len); end
            checks++; if (obs_stalls !== 0) begin errors++; $display("FAIL bp_stable pkt=%0d: got %0d changes while stalled want 0", p, obs_stalls); end
            exp_seq++;
            checks++; if (seq_o !== exp_seq) begin errors++; $display("FAIL bp_seq pkt=%0d: got %h want %h", p, seq_o, exp_seq); end
            if (p == 255) begin
                checks++; if (seq_o !== 8'h00) begin errors++; $display("FAIL seq_wrap: got %h want 00", seq_o); end
            end
        end
    endtask

    initial begin
        reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        len_i = '0; unpacked_i = '0; exp_seq = 8'h00;
        test_reset();
        test_all_ones();
        test_partial();
        test_zero_len();
        test_back_to_back();
        test_async_reset();
        test_backpressure();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
